// File: rtl/seq_divider.sv
// Multi-cycle restoring divider (RISC-V DIV/DIVU/REM/REMU semantics) sharing one add/subtract datapath.
// Done pulses n+1 cycles after an accepted start (1 cycle for divide by zero); start is ignored while busy.

module adder #(
  parameter int w = 9
) (
  input  logic [w-1:0] x,
  input  logic [w-1:0] y,
  input  logic         nadd_sub,
  output logic [w-1:0] sum,
  output logic         carry
);
  logic [w-1:0] y_eff;

  assign y_eff        = nadd_sub ? ~y : y;
  assign {carry, sum} = {1'b0, x} + {1'b0, y_eff} + {{w{1'b0}}, nadd_sub};
endmodule

module seq_divider #(
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         is_signed,
  input  logic [n-1:0] dividend,
  input  logic [n-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [n-1:0] quotient,
  output logic [n-1:0] remainder,
  output logic         div_by_zero
);
  localparam int             cw   = $clog2(n + 1);
  localparam logic [cw-1:0]  last = cw'(n - 1);
  localparam logic [n-1:0]   one  = {{(n-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t        state, next_state;
  logic [n-1:0]  r, q, dvs_mag, dvd_orig;
  logic [cw-1:0] count;
  logic          sign_q, sign_r, dbz;
  logic          accept, dvs_zero, take, carry;
  logic [n:0]    t, diff;
  logic [n-1:0]  dvd_abs, dvs_abs;

  assign accept   = start && (state == IDLE || state == DONE);
  assign dvs_zero = (divisor == '0);
  assign dvd_abs  = (is_signed && dividend[n-1]) ? (~dividend + one) : dividend;
  assign dvs_abs  = (is_signed && divisor[n-1])  ? (~divisor + one)  : divisor;

  assign t = {r, q[n-1]};

  adder #(.w(n + 1)) u_sub (
    .x        (t),
    .y        ({1'b0, dvs_mag}),
    .nadd_sub (1'b1),
    .sum      (diff),
    .carry    (carry)
  );

  // With R < divisor, diff[n] is simply ~carry; both are checked so every result bit is consumed.
  assign take = carry & ~diff[n];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (start) next_state = dvs_zero ? FIX : RUN;
      RUN:  if (count == last) next_state = FIX;
      FIX:  next_state = DONE;
      DONE: next_state = start ? (dvs_zero ? FIX : RUN) : IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r           <= '0;
      q           <= '0;
      dvs_mag     <= '0;
      dvd_orig    <= '0;
      count       <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      dbz         <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      sign_q   <= is_signed & (dividend[n-1] ^ divisor[n-1]);
      sign_r   <= is_signed & dividend[n-1];
      q        <= dvd_abs;
      dvs_mag  <= dvs_abs;
      dvd_orig <= dividend;
      r        <= '0;
      count    <= '0;
      dbz      <= dvs_zero;
    end else if (state == RUN) begin
      r     <= take ? diff[n-1:0] : t[n-1:0];
      q     <= {q[n-2:0], take};
      count <= count + 1'b1;
    end else if (state == FIX) begin
      if (dbz) begin
        quotient    <= '1;
        remainder   <= dvd_orig;
        div_by_zero <= 1'b1;
      end else begin
        quotient    <= sign_q ? (~q + one) : q;
        remainder   <= sign_r ? (~r + one) : r;
        div_by_zero <= 1'b0;
      end
    end
  end

  assign busy = (state == RUN) || (state == FIX);
  assign done = (state == DONE);
endmodule
